// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph table for the 7-segment scan capture slice.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  localparam int N_DIGITS = 4;
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [15:0][6:0] GLYPH_TAB = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
                                            GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                            GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
                                            GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-low segment pattern to hex nibble, flagging non-glyph patterns.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);
  always_comb begin
    legal = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++)
      if (seg == GLYPH_TAB[i]) begin
        legal = 1'b1;
        nibble = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 7-segment bus and rebuilds the 4-digit hex frame.
// The state literal SETTLE is package-qualified because the settle parameter shares its name.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int MAX_BLANK = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  AN_EN,
  input  logic [6:0]  SEG,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        err_multi,
  output logic        err_order,
  output logic        err_seg,
  output logic        err_timeout
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(MAX_BLANK + 1);
  state_t st_q, st_d;
  logic [3:0] an_q, lows;
  logic [6:0] seg_q;
  logic [1:0] idx_q, idx_d, exp_q, exp_d, low_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0] valid_q, valid_d;
  logic seq_q, seq_d, frame_q, frame_d;
  logic em_q, em_d, eo_q, eo_d, es_q, es_d, et_q, et_d;
  logic blank, one, multi, same, cap, legal, in_ord;
  logic [3:0] nib;

  seg7_to_hex u_dec (.seg(seg_q), .legal(legal), .nibble(nib));

  assign lows    = ~an_q;
  assign blank   = an_q == 4'hF;
  assign one     = !blank && ((lows & (lows - 4'd1)) == 4'd0);
  assign multi   = !blank && !one;
  assign low_idx = lows[3] ? 2'd3 : lows[2] ? 2'd2 : lows[1] ? 2'd1 : 2'd0;
  assign same    = one && low_idx == idx_q;
  assign in_ord  = idx_q == exp_q;

  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    exp_d = exp_q;
    seq_d = seq_q;
    digits_d = digits_q;
    valid_d = valid_q;
    frame_d = 1'b0;
    em_d = em_q;
    eo_d = eo_q;
    es_d = es_q;
    et_d = et_q;
    cap = 1'b0;
    blank_d = !blank ? '0 : blank_q == BW'(MAX_BLANK) ? blank_q : blank_q + 1'b1;
    if (multi) begin
      em_d = 1'b1;
      st_d = IDLE;
    end else if (blank) st_d = IDLE;
    else if (st_q == IDLE || !same) begin
      st_d = seg7_pkg::SETTLE;
      idx_d = low_idx;
      cnt_d = CW'(1);
    end else if (st_q == seg7_pkg::SETTLE) begin
      cnt_d = cnt_q + 1'b1;
      cap = cnt_d == CW'(SETTLE);
      st_d = cap ? HOLD : st_q;
    end
    // an in-order digit3 opens a new frame; any out-of-order capture resyncs the scan
    if (cap) begin
      if (legal) digits_d[{idx_q, 2'b00} +: 4] = nib;
      es_d = es_q | !legal;
      eo_d = eo_q | !in_ord;
      valid_d = (!in_ord || idx_q == 2'd3) ? 4'd0 : valid_q;
      valid_d[idx_q] = legal;
      exp_d = idx_q - 2'd1;
      seq_d = in_ord && legal && (idx_q == 2'd3 || seq_q);
      frame_d = in_ord && legal && seq_q && idx_q == 2'd0;
    end
    if (blank && blank_q == BW'(MAX_BLANK - 1)) begin
      et_d = 1'b1;
      valid_d = '0;
      exp_d = 2'd3;
    end
    if (clear) begin
      st_d = IDLE;
      digits_d = digits_q;
      valid_d = '0;
      exp_d = 2'd3;
      seq_d = 1'b0;
      frame_d = 1'b0;
      blank_d = '0;
      {em_d, eo_d, es_d, et_d} = '0;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      an_q <= 4'hF;
      seg_q <= 7'h7F;
      st_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      exp_q <= 2'd3;
      blank_q <= '0;
      seq_q <= 1'b0;
      digits_q <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      {em_q, eo_q, es_q, et_q} <= '0;
    end else begin
      an_q <= AN_EN;
      seg_q <= SEG;
      st_q <= st_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      blank_q <= blank_d;
      seq_q <= seq_d;
      digits_q <= digits_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      {em_q, eo_q, es_q, et_q} <= {em_d, eo_d, es_d, et_d};
    end

  assign digits      = digits_q;
  assign valid       = valid_q;
  assign frame_done  = frame_q;
  assign err_multi   = em_q;
  assign err_order   = eo_q;
  assign err_seg     = es_q;
  assign err_timeout = et_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scan sweeps with hand-computed frames and error flags.
module tb_seg7_scan_capture;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic [3:0] AN_EN = 4'hF;
  logic [6:0] SEG = 7'h7F;
  logic [15:0] digits;
  logic [3:0] valid;
  logic frame_done, err_multi, err_order, err_seg, err_timeout;
  int nv = 0, nbad = 0, nframes = 0, f0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BAD = 7'b1111111;

  seg7_scan_capture dut (
    .clk(clk), .reset(reset), .AN_EN(AN_EN), .SEG(SEG), .clear(clear),
    .digits(digits), .valid(valid), .frame_done(frame_done),
    .err_multi(err_multi), .err_order(err_order), .err_seg(err_seg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (reset && frame_done) nframes++;

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN_EN = an;
    SEG = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic digit(input int i, input logic [6:0] seg);
    drive(~(4'b0001 << i), seg, 8);
    drive(4'hF, 7'h7F, 24);
  endtask

  task automatic sweep(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
    digit(3, a);
    digit(2, b);
    digit(1, c);
    digit(0, d);
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    nv++; if (digits !== 16'h0) begin nbad++; $display("FAIL reset_digits got %h want 0000", digits); end
    nv++; if (valid !== 4'h0) begin nbad++; $display("FAIL reset_valid got %h want 0", valid); end
    nv++; if ({frame_done, err_multi, err_order, err_seg, err_timeout} !== 5'b0)
      begin nbad++; $display("FAIL reset_flags got %b want 00000", {frame_done, err_multi, err_order, err_seg, err_timeout}); end
    reset = 1'b1;
    drive(4'hF, 7'h7F, 2);
  endtask

  task automatic test_sweep;
    f0 = nframes;
    sweep(S1, S2, S3, S4);
    nv++; if (digits !== 16'h1234) begin nbad++; $display("FAIL sweep_digits got %h want 1234", digits); end
    nv++; if (valid !== 4'hF) begin nbad++; $display("FAIL sweep_valid got %h want f", valid); end
    nv++; if (nframes - f0 !== 1) begin nbad++; $display("FAIL sweep_frames got %0d want 1", nframes - f0); end
    nv++; if ({err_multi, err_order, err_seg, err_timeout} !== 4'b0)
      begin nbad++; $display("FAIL sweep_errs got %b want 0000", {err_multi, err_order, err_seg, err_timeout}); end
  endtask

  task automatic test_multi;
    f0 = nframes;
    digit(3, S5);
    digit(2, S6);
    drive(4'b0011, S9, 1);
    drive(4'hF, 7'h7F, 8);
    digit(1, S7);
    digit(0, S8);
    nv++; if (err_multi !== 1'b1) begin nbad++; $display("FAIL multi_flag got %b want 1", err_multi); end
    nv++; if (digits !== 16'h5678) begin nbad++; $display("FAIL multi_digits got %h want 5678", digits); end
    nv++; if (nframes - f0 !== 1) begin nbad++; $display("FAIL multi_frames got %0d want 1", nframes - f0); end
    nv++; if (err_order !== 1'b0) begin nbad++; $display("FAIL multi_order got %b want 0", err_order); end
  endtask

  task automatic test_order;
    pulse_clear();
    nv++; if (err_multi !== 1'b0) begin nbad++; $display("FAIL clear_multi got %b want 0", err_multi); end
    nv++; if (valid !== 4'h0) begin nbad++; $display("FAIL clear_valid got %h want 0", valid); end
    f0 = nframes;
    digit(3, SA);
    digit(1, SB);
    digit(2, SC);
    digit(0, SD);
    nv++; if (err_order !== 1'b1) begin nbad++; $display("FAIL order_flag got %b want 1", err_order); end
    nv++; if (nframes - f0 !== 0) begin nbad++; $display("FAIL order_frames got %0d want 0", nframes - f0); end
    nv++; if (digits !== 16'hACBD) begin nbad++; $display("FAIL order_digits got %h want acbd", digits); end
    nv++; if (valid !== 4'h1) begin nbad++; $display("FAIL order_valid got %h want 1", valid); end
    f0 = nframes;
    sweep(SE, SF, S0, S1);
    nv++; if (nframes - f0 !== 1) begin nbad++; $display("FAIL resync_frames got %0d want 1", nframes - f0); end
    nv++; if (digits !== 16'hEF01) begin nbad++; $display("FAIL resync_digits got %h want ef01", digits); end
    nv++; if (valid !== 4'hF) begin nbad++; $display("FAIL resync_valid got %h want f", valid); end
  endtask

  task automatic test_seg;
    pulse_clear();
    f0 = nframes;
    sweep(S9, BAD, S3, S4);
    nv++; if (err_seg !== 1'b1) begin nbad++; $display("FAIL seg_flag got %b want 1", err_seg); end
    nv++; if (valid !== 4'hB) begin nbad++; $display("FAIL seg_valid got %h want b", valid); end
    nv++; if (digits[11:8] !== 4'hF) begin nbad++; $display("FAIL seg_hold got %h want f", digits[11:8]); end
    nv++; if (digits !== 16'h9F34) begin nbad++; $display("FAIL seg_digits got %h want 9f34", digits); end
    nv++; if (nframes - f0 !== 0) begin nbad++; $display("FAIL seg_frames got %0d want 0", nframes - f0); end
    nv++; if (err_order !== 1'b0) begin nbad++; $display("FAIL seg_order got %b want 0", err_order); end
  endtask

  task automatic test_timeout;
    pulse_clear();
    sweep(S1, S2, S3, S4);
    drive(4'b1110, S9, 1);
    drive(4'hF, 7'h7F, 60);
    nv++; if (digits !== 16'h1234) begin nbad++; $display("FAIL short_digits got %h want 1234", digits); end
    nv++; if (err_timeout !== 1'b0) begin nbad++; $display("FAIL timeout_early got %b want 0", err_timeout); end
    nv++; if (valid !== 4'hF) begin nbad++; $display("FAIL timeout_prevalid got %h want f", valid); end
    drive(4'hF, 7'h7F, 5);
    nv++; if (err_timeout !== 1'b1) begin nbad++; $display("FAIL timeout_flag got %b want 1", err_timeout); end
    nv++; if (valid !== 4'h0) begin nbad++; $display("FAIL timeout_valid got %h want 0", valid); end
  endtask

  task automatic test_reset_mid;
    pulse_clear();
    f0 = nframes;
    digit(3, S1);
    digit(2, S2);
    drive(4'b1101, S3, 5);
    #2;
    reset = 1'b0;
    #1;
    nv++; if (digits !== 16'h0) begin nbad++; $display("FAIL midreset_digits got %h want 0000", digits); end
    nv++; if ({valid, err_timeout} !== 5'b0) begin nbad++; $display("FAIL midreset_valid got %b want 00000", {valid, err_timeout}); end
    drive(4'hF, 7'h7F, 2);
    reset = 1'b1;
    drive(4'hF, 7'h7F, 6);
    nv++; if (nframes - f0 !== 0) begin nbad++; $display("FAIL midreset_frames got %0d want 0", nframes - f0); end
  endtask

  task automatic test_clear;
    drive(4'b0000, 7'h7F, 1);
    drive(4'hF, 7'h7F, 3);
    digit(1, S7);
    nv++; if (valid !== 4'h2) begin nbad++; $display("FAIL ooo_valid got %h want 2", valid); end
    digit(2, BAD);
    nv++; if ({err_multi, err_order, err_seg} !== 3'b111)
      begin nbad++; $display("FAIL errs_set got %b want 111", {err_multi, err_order, err_seg}); end
    pulse_clear();
    nv++; if ({err_multi, err_order, err_seg, err_timeout} !== 4'b0)
      begin nbad++; $display("FAIL clear_errs got %b want 0000", {err_multi, err_order, err_seg, err_timeout}); end
    nv++; if (valid !== 4'h0) begin nbad++; $display("FAIL clear_valid2 got %h want 0", valid); end
    nv++; if (digits !== 16'h0070) begin nbad++; $display("FAIL clear_digits got %h want 0070", digits); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_multi();
    test_order();
    test_seg();
    test_timeout();
    test_reset_mid();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nbad);
    $finish;
  end
endmodule
